mcb_dat_path: RTL and testbench
===============================

// Module: mcb_dat_path
// PURPOSE
//  SDR SDRAM DQ/DQM datapath; sits directly downstream of the MCB data controller.
//  Consumes d_dp_ie, d_dp_oe and d_wr_ld to capture read beats from the DQ pins and to
//  load/drive write beats and masks. Counts beats per burst and flags the last beat to the
//  host. Detects ie/oe overlap and blocks DQ drive while the overlap is present.
// PARAMETERS
//  DQ_W   16  SDRAM data width, bits
//  DM_W   2   data-mask width; must equal DQ_W/8
//  BL     4   beats per unit burst; a burst is BL*(c_bst_num+1) beats, max 4*BL
// PORTS
//  mcb_clk        in   1     sole clock; all flops rise-edge
//  mcb_rst        in   1     asynchronous reset, active-high
//  mcb_sclr_n     in   1     synchronous clear, active-low
//  c_bst_num      in   2     burst multiplier; sampled on the first beat of each burst
//  d_dp_ie        in   1     DQ pins carry valid read data this cycle
//  d_dp_oe        in   1     drive DQ in the next cycle
//  d_wr_ld        in   1     load write register from mcb_wdat/mcb_wdm this cycle
//  mcb_wdat       in   DQ_W  host write data
//  mcb_wdm        in   DM_W  host write byte mask; 1 = masked
//  mcb_wdat_last  out  1     combinational; d_wr_ld on the last write beat of the burst
//  mcb_rdat       out  DQ_W  read data to host
//  mcb_rdat_vld   out  1     mcb_rdat valid; one pulse per beat
//  mcb_rdat_last  out  1     qualifies the last read beat; only asserted with mcb_rdat_vld
//  sdr_dq_i       in   DQ_W  DQ pad input
//  sdr_dq_o       out  DQ_W  DQ pad output data
//  sdr_dq_oe      out  1     DQ pad output enable
//  sdr_dqm        out  DM_W  DQM pins
//  dp_err         out  1     sticky protocol error: d_dp_ie and d_dp_oe high together
// BEHAVIOUR
//  Reset (mcb_rst=1, async) and sclr (mcb_sclr_n=0 at an edge): all outputs go to 0.
//   Beat counters go to 0 and the latched burst length goes to BL. dp_err is also cleared.
//  Read path: a capture is d_dp_ie=1 with d_dp_oe=0.
//   On a capture edge, sdr_dq_i is registered into mcb_rdat and mcb_rdat_vld is set for
//   the next cycle. Latency is 1 cycle from pin to host.
//   mcb_rdat holds its value between captures.
//  Read beat counter (rbeat):
//   - at rbeat==0 on a capture, latch nbeat_r = BL*(c_bst_num+1);
//   - increment per capture;
//   - on a capture with rbeat == nbeat_r-1: set mcb_rdat_last alongside vld, rbeat wraps to 0.
//  Write path: on a d_wr_ld edge, the write register takes mcb_wdat and mcb_wdm.
//   sdr_dq_o always shows the write register.
//   sdr_dq_oe <= d_dp_oe & ~d_dp_ie (registered); data and OE are aligned when d_wr_ld and
//   d_dp_oe arrive in the same cycle.
//   sdr_dqm <= (d_dp_oe & ~d_dp_ie) ? mcb_wdm-path value : {DM_W{1'b0}} (registered).
//   DQM is forced to 0 outside writes so read beats are not masked.
//  Write beat counter (wbeat): same rules as rbeat, but advanced by d_wr_ld.
//   nbeat_w is latched from c_bst_num at wbeat==0.
//   mcb_wdat_last = d_wr_ld & (wbeat == nbeat_w-1).
//  Boundaries:
//   - d_dp_ie & d_dp_oe together: no capture, no drive (next oe=0), dp_err set sticky.
//     This cycle does not advance rbeat. d_wr_ld is still honoured.
//   - back-to-back bursts: the wrap to 0 re-samples c_bst_num on the next first beat.
//   - reset or sclr mid-burst: counters restart; the partial burst produces no last flag.
//   - c_bst_num changing mid-burst: ignored until the wrap.
// CONFIGURATION
//  MCB_DP_IN_REG_EN defined: adds a pad-input register stage on sdr_dq_i and on the
//   capture strobe.
//   - read latency becomes 2 cycles; the last flag is delayed equally;
//   - the conflict check still uses undelayed ie/oe.
//  Not defined: read latency is 1 cycle as above. Write path is identical in both builds.
// TESTING
//  1 reset: mcb_rst pulse mid-run -> all outputs 0 immediately (async), no clock needed.
//  2 read bst_num=0, BL=4: ie high 4 cycles with DQ=0x1111..0x4444 -> vld 4 cycles,
//     1 cycle later, data in order, last on 0x4444 only.
//  3 read bst_num=1: 8 ie cycles -> 8 vld, last on beat 8 only.
//     Then a bst_num=0 burst -> last on beat 4.
//  4 write bst_num=0: wr_ld+oe with wdat 0xA5A5, wdm 2'b01 -> next cycle dq_o=0xA5A5,
//     oe=1, dqm=01; wdat_last on beat 4; idle after -> oe=0, dqm=00.
//  5 conflict: ie=oe=1 for 1 cycle -> dp_err=1 (sticky), oe stays 0, no vld, rbeat unchanged;
//     sclr clears dp_err.
//  6 sclr after 2 of 4 read beats -> no last; next burst of 4 -> last on its 4th beat.
//     Rerun 2 with MCB_DP_IN_REG_EN -> latency 2.

Source files
------------

// File: rtl/mcb_dat_path.sv
// SDR SDRAM DQ/DQM datapath: read capture, write drive, per-burst beat counting, ie/oe conflict flag.
// Optional MCB_DP_IN_REG_EN adds a pad-input register stage on the read path (read latency 2).
module mcb_dat_path #(
    parameter int DQ_W = 16,
    parameter int DM_W = 2,
    parameter int BL   = 4
) (
    input  logic            mcb_clk,
    input  logic            mcb_rst,
    input  logic            mcb_sclr_n,
    input  logic [1:0]      c_bst_num,
    input  logic            d_dp_ie,
    input  logic            d_dp_oe,
    input  logic            d_wr_ld,
    input  logic [DQ_W-1:0] mcb_wdat,
    input  logic [DM_W-1:0] mcb_wdm,
    output logic            mcb_wdat_last,
    output logic [DQ_W-1:0] mcb_rdat,
    output logic            mcb_rdat_vld,
    output logic            mcb_rdat_last,
    input  logic [DQ_W-1:0] sdr_dq_i,
    output logic [DQ_W-1:0] sdr_dq_o,
    output logic            sdr_dq_oe,
    output logic [DM_W-1:0] sdr_dqm,
    output logic            dp_err
);

    // Counter width holds the largest burst length, 4*BL.
    localparam int CW = $clog2(4 * BL) + 1;

    function automatic logic [CW-1:0] burst_len(input logic [1:0] bst);
        return CW'(BL * (int'(bst) + 1));
    endfunction

    logic conflict;
    logic capture;
    logic drive_next;

    assign conflict   = d_dp_ie & d_dp_oe;
    assign capture    = d_dp_ie & ~d_dp_oe;
    assign drive_next = d_dp_oe & ~d_dp_ie;

    // ---------------- read front end ----------------
    logic [DQ_W-1:0] rd_dq;
    logic            rd_cap;
    logic [1:0]      rd_bst;

`ifdef MCB_DP_IN_REG_EN
    logic [DQ_W-1:0] dq_in_reg;
    logic            cap_in_reg;
    logic [1:0]      bst_in_reg;

    // Burst multiplier travels with the strobe so it is sampled on the delayed first beat.
    always_ff @(posedge mcb_clk or posedge mcb_rst) begin
        if (mcb_rst) begin
            dq_in_reg  <= '0;
            cap_in_reg <= 1'b0;
            bst_in_reg <= 2'b00;
        end else if (!mcb_sclr_n) begin
            dq_in_reg  <= '0;
            cap_in_reg <= 1'b0;
            bst_in_reg <= 2'b00;
        end else begin
            dq_in_reg  <= sdr_dq_i;
            cap_in_reg <= capture;
            bst_in_reg <= c_bst_num;
        end
    end

    assign rd_dq  = dq_in_reg;
    assign rd_cap = cap_in_reg;
    assign rd_bst = bst_in_reg;
`else
    assign rd_dq  = sdr_dq_i;
    assign rd_cap = capture;
    assign rd_bst = c_bst_num;
`endif

    // ---------------- read beat counter and capture ----------------
    logic [CW-1:0]   rbeat_reg, rbeat_next;
    logic [CW-1:0]   nbeat_r_reg, nbeat_r_next;
    logic [CW-1:0]   rnbeat_cur;
    logic            rd_is_last;
    logic [DQ_W-1:0] rdat_reg;
    logic            rdat_vld_reg;
    logic            rdat_last_reg;

    always_comb begin
        rnbeat_cur   = (rbeat_reg == '0) ? burst_len(rd_bst) : nbeat_r_reg;
        rd_is_last   = (rbeat_reg == rnbeat_cur - 1'b1);
        rbeat_next   = rbeat_reg;
        nbeat_r_next = nbeat_r_reg;
        if (rd_cap) begin
            rbeat_next   = rd_is_last ? '0 : rbeat_reg + 1'b1;
            nbeat_r_next = rnbeat_cur;
        end
    end

    always_ff @(posedge mcb_clk or posedge mcb_rst) begin
        if (mcb_rst) begin
            rbeat_reg     <= '0;
            nbeat_r_reg   <= CW'(BL);
            rdat_reg      <= '0;
            rdat_vld_reg  <= 1'b0;
            rdat_last_reg <= 1'b0;
        end else if (!mcb_sclr_n) begin
            rbeat_reg     <= '0;
            nbeat_r_reg   <= CW'(BL);
            rdat_reg      <= '0;
            rdat_vld_reg  <= 1'b0;
            rdat_last_reg <= 1'b0;
        end else begin
            rbeat_reg     <= rbeat_next;
            nbeat_r_reg   <= nbeat_r_next;
            rdat_vld_reg  <= rd_cap;
            rdat_last_reg <= rd_cap & rd_is_last;
            if (rd_cap) begin
                rdat_reg <= rd_dq;
            end
        end
    end

    assign mcb_rdat      = rdat_reg;
    assign mcb_rdat_vld  = rdat_vld_reg;
    assign mcb_rdat_last = rdat_last_reg;

    // ---------------- write path ----------------
    logic [CW-1:0]   wbeat_reg, wbeat_next;
    logic [CW-1:0]   nbeat_w_reg, nbeat_w_next;
    logic [CW-1:0]   wnbeat_cur;
    logic            wr_is_last;
    logic [DQ_W-1:0] wdat_reg;
    logic [DM_W-1:0] wdm_reg;
    logic [DM_W-1:0] dqm_next;
    logic [DM_W-1:0] dqm_reg;
    logic            dq_oe_reg;
    logic            dp_err_reg;

    always_comb begin
        wnbeat_cur   = (wbeat_reg == '0) ? burst_len(c_bst_num) : nbeat_w_reg;
        wr_is_last   = (wbeat_reg == wnbeat_cur - 1'b1);
        wbeat_next   = wbeat_reg;
        nbeat_w_next = nbeat_w_reg;
        if (d_wr_ld) begin
            wbeat_next   = wr_is_last ? '0 : wbeat_reg + 1'b1;
            nbeat_w_next = wnbeat_cur;
        end
    end

    // The mask bypasses the write register so DQM lines up with data loaded on the same edge.
    genvar gi;
    generate
        for (gi = 0; gi < DM_W; gi++) begin : g_dqm_lane
            assign dqm_next[gi] = drive_next & (d_wr_ld ? mcb_wdm[gi] : wdm_reg[gi]);
        end
    endgenerate

    always_ff @(posedge mcb_clk or posedge mcb_rst) begin
        if (mcb_rst) begin
            wbeat_reg   <= '0;
            nbeat_w_reg <= CW'(BL);
            wdat_reg    <= '0;
            wdm_reg     <= '0;
            dqm_reg     <= '0;
            dq_oe_reg   <= 1'b0;
            dp_err_reg  <= 1'b0;
        end else if (!mcb_sclr_n) begin
            wbeat_reg   <= '0;
            nbeat_w_reg <= CW'(BL);
            wdat_reg    <= '0;
            wdm_reg     <= '0;
            dqm_reg     <= '0;
            dq_oe_reg   <= 1'b0;
            dp_err_reg  <= 1'b0;
        end else begin
            wbeat_reg   <= wbeat_next;
            nbeat_w_reg <= nbeat_w_next;
            dqm_reg     <= dqm_next;
            dq_oe_reg   <= drive_next;
            dp_err_reg  <= dp_err_reg | conflict;
            if (d_wr_ld) begin
                wdat_reg <= mcb_wdat;
                wdm_reg  <= mcb_wdm;
            end
        end
    end

    assign mcb_wdat_last = d_wr_ld & wr_is_last;
    assign sdr_dq_o      = wdat_reg;
    assign sdr_dq_oe     = dq_oe_reg;
    assign sdr_dqm       = dqm_reg;
    assign dp_err        = dp_err_reg;

endmodule

// File: tb/tb_mcb_dat_path.sv
// Directed bench for mcb_dat_path with a read scoreboard (data, last flag, arrival cycle).
module tb_mcb_dat_path;

    localparam int DQ_W = 16;
    localparam int DM_W = 2;
    localparam int BL   = 4;
`ifdef MCB_DP_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic            mcb_clk = 1'b0;
    logic            mcb_rst;
    logic            mcb_sclr_n;
    logic [1:0]      c_bst_num;
    logic            d_dp_ie;
    logic            d_dp_oe;
    logic            d_wr_ld;
    logic [DQ_W-1:0] mcb_wdat;
    logic [DM_W-1:0] mcb_wdm;
    logic            mcb_wdat_last;
    logic [DQ_W-1:0] mcb_rdat;
    logic            mcb_rdat_vld;
    logic            mcb_rdat_last;
    logic [DQ_W-1:0] sdr_dq_i;
    logic [DQ_W-1:0] sdr_dq_o;
    logic            sdr_dq_oe;
    logic [DM_W-1:0] sdr_dqm;
    logic            dp_err;

    mcb_dat_path #(.DQ_W(DQ_W), .DM_W(DM_W), .BL(BL)) dut (
        .mcb_clk       (mcb_clk),
        .mcb_rst       (mcb_rst),
        .mcb_sclr_n    (mcb_sclr_n),
        .c_bst_num     (c_bst_num),
        .d_dp_ie       (d_dp_ie),
        .d_dp_oe       (d_dp_oe),
        .d_wr_ld       (d_wr_ld),
        .mcb_wdat      (mcb_wdat),
        .mcb_wdm       (mcb_wdm),
        .mcb_wdat_last (mcb_wdat_last),
        .mcb_rdat      (mcb_rdat),
        .mcb_rdat_vld  (mcb_rdat_vld),
        .mcb_rdat_last (mcb_rdat_last),
        .sdr_dq_i      (sdr_dq_i),
        .sdr_dq_o      (sdr_dq_o),
        .sdr_dq_oe     (sdr_dq_oe),
        .sdr_dqm       (sdr_dqm),
        .dp_err        (dp_err)
    );

    always #5 mcb_clk = ~mcb_clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge mcb_clk) cyc <= cyc + 1;

    typedef struct {
        logic [DQ_W-1:0] data;
        logic            last;
        int              cyc;
    } rd_exp_t;

    rd_exp_t rq[$];
    rd_exp_t mon_e;

    int m_rbeat = 0, m_rn = BL;
    int m_wbeat = 0, m_wn = BL;
    logic [DQ_W-1:0] prev_wdat;
    logic [DM_W-1:0] prev_wdm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Read monitor: every vld pulse pops one expected beat.
    always @(negedge mcb_clk) begin
        if (mcb_rdat_vld) begin
            checks++;
            assert (rq.size() > 0) else begin
                failures++;
                $error("FAIL rd_unexpected observed vld=1 data=0x%0h expected no beat", mcb_rdat);
            end
            if (rq.size() > 0) begin
                mon_e = rq.pop_front();
                chk("rd_data", 32'(mcb_rdat), 32'(mon_e.data));
                chk("rd_last", 32'(mcb_rdat_last), 32'(mon_e.last));
                chk("rd_latency_cycle", cyc, mon_e.cyc);
                $display("rd beat data=0x%04h last=%0d cyc=%0d", mcb_rdat, mcb_rdat_last, cyc);
            end
        end else if (mcb_rdat_last) begin
            chk("rd_last_without_vld", 32'(mcb_rdat_last), 32'(0));
        end
    end

    task automatic idle();
        @(posedge mcb_clk); #1;
        d_dp_ie = 1'b0; d_dp_oe = 1'b0; d_wr_ld = 1'b0;
    endtask

    task automatic rd_beat(input logic [DQ_W-1:0] d, input logic [1:0] bst);
        rd_exp_t e;
        @(posedge mcb_clk); #1;
        d_dp_ie = 1'b1; d_dp_oe = 1'b0; d_wr_ld = 1'b0;
        sdr_dq_i = d; c_bst_num = bst;
        if (m_rbeat == 0) m_rn = BL * (int'(bst) + 1);
        e.data = d;
        e.last = (m_rbeat == m_rn - 1);
        e.cyc  = cyc + LAT;
        rq.push_back(e);
        m_rbeat = e.last ? 0 : m_rbeat + 1;
    endtask

    task automatic drain();
        repeat (LAT + 2) idle();
        chk("rd_queue_drained", rq.size(), 0);
    endtask

    task automatic wr_beat(input logic [DQ_W-1:0] d, input logic [DM_W-1:0] m,
                           input logic [1:0] bst, input bit chk_prev);
        logic exp_last;
        @(posedge mcb_clk); #1;
        if (chk_prev) begin
            chk("wr_dq_o", 32'(sdr_dq_o), 32'(prev_wdat));
            chk("wr_dq_oe", 32'(sdr_dq_oe), 32'(1));
            chk("wr_dqm", 32'(sdr_dqm), 32'(prev_wdm));
        end
        d_wr_ld = 1'b1; d_dp_oe = 1'b1; d_dp_ie = 1'b0;
        mcb_wdat = d; mcb_wdm = m; c_bst_num = bst;
        if (m_wbeat == 0) m_wn = BL * (int'(bst) + 1);
        exp_last = (m_wbeat == m_wn - 1);
        m_wbeat = exp_last ? 0 : m_wbeat + 1;
        #1;
        chk("wdat_last", 32'(mcb_wdat_last), 32'(exp_last));
        $display("wr beat data=0x%04h dm=%b wdat_last=%0d", d, m, mcb_wdat_last);
        prev_wdat = d; prev_wdm = m;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdat"}, 32'(mcb_rdat), 32'(0));
        chk({tag, "_rdat_vld"}, 32'(mcb_rdat_vld), 32'(0));
        chk({tag, "_rdat_last"}, 32'(mcb_rdat_last), 32'(0));
        chk({tag, "_dq_o"}, 32'(sdr_dq_o), 32'(0));
        chk({tag, "_dq_oe"}, 32'(sdr_dq_oe), 32'(0));
        chk({tag, "_dqm"}, 32'(sdr_dqm), 32'(0));
        chk({tag, "_dp_err"}, 32'(dp_err), 32'(0));
    endtask

    task automatic model_clear();
        m_rbeat = 0; m_rn = BL; m_wbeat = 0; m_wn = BL;
    endtask

    initial begin
        mcb_rst = 1'b1; mcb_sclr_n = 1'b1; c_bst_num = 2'd0;
        d_dp_ie = 1'b0; d_dp_oe = 1'b0; d_wr_ld = 1'b0;
        mcb_wdat = '0; mcb_wdm = '0; sdr_dq_i = '0;
        prev_wdat = '0; prev_wdm = '0;
        repeat (2) @(posedge mcb_clk);
        #1 mcb_rst = 1'b0;
        @(negedge mcb_clk);
        chk_all_zero("reset");

        // Single-unit read burst
        rd_beat(16'h1111, 2'd0);
        rd_beat(16'h2222, 2'd0);
        rd_beat(16'h3333, 2'd0);
        rd_beat(16'h4444, 2'd0);
        drain();

        // Double burst with c_bst_num wiggling mid-burst, then a back-to-back single burst
        for (int i = 0; i < 8; i++)
            rd_beat(16'h8000 + 16'(i), (i == 0) ? 2'd1 : 2'd3);
        for (int i = 0; i < 4; i++)
            rd_beat(16'h9000 + 16'(i), 2'd0);
        drain();

        // Write burst with masks
        wr_beat(16'hA5A5, 2'b01, 2'd0, 1'b0);
        wr_beat(16'h5A5A, 2'b10, 2'd2, 1'b1);
        wr_beat(16'hC3C3, 2'b00, 2'd2, 1'b1);
        wr_beat(16'h3C3C, 2'b11, 2'd2, 1'b1);
        @(posedge mcb_clk); #1;
        chk("wr_dq_o_final", 32'(sdr_dq_o), 32'(prev_wdat));
        chk("wr_dq_oe_final", 32'(sdr_dq_oe), 32'(1));
        chk("wr_dqm_final", 32'(sdr_dqm), 32'(prev_wdm));
        d_wr_ld = 1'b0; d_dp_oe = 1'b0;
        @(posedge mcb_clk); #1;
        chk("wr_idle_oe", 32'(sdr_dq_oe), 32'(0));
        chk("wr_idle_dqm", 32'(sdr_dqm), 32'(0));
        chk("wr_idle_dq_o_hold", 32'(sdr_dq_o), 32'(16'h3C3C));

        // Conflict in the middle of a read burst
        rd_beat(16'h5001, 2'd0);
        rd_beat(16'h5002, 2'd0);
        @(posedge mcb_clk); #1;
        d_dp_ie = 1'b1; d_dp_oe = 1'b1; sdr_dq_i = 16'hDEAD;
        @(posedge mcb_clk); #1;
        d_dp_ie = 1'b0; d_dp_oe = 1'b0;
        chk("conflict_dp_err", 32'(dp_err), 32'(1));
        chk("conflict_no_oe", 32'(sdr_dq_oe), 32'(0));
        rd_beat(16'h5003, 2'd0);
        rd_beat(16'h5004, 2'd0);
        drain();
        chk("conflict_dp_err_sticky", 32'(dp_err), 32'(1));

        // Asynchronous reset mid-cycle with the write path driving
        wr_beat(16'h1234, 2'b10, 2'd0, 1'b0);
        @(posedge mcb_clk); #1;
        d_wr_ld = 1'b0; d_dp_oe = 1'b0;
        chk("pre_reset_oe", 32'(sdr_dq_oe), 32'(1));
        #1 mcb_rst = 1'b1;
        #1 chk_all_zero("async_reset");
        model_clear();
        @(posedge mcb_clk); #1 mcb_rst = 1'b0;

        // Conflict again, then synchronous clear
        @(posedge mcb_clk); #1;
        d_dp_ie = 1'b1; d_dp_oe = 1'b1;
        idle();
        chk("conflict2_dp_err", 32'(dp_err), 32'(1));
        @(posedge mcb_clk); #1 mcb_sclr_n = 1'b0;
        @(posedge mcb_clk); #1 mcb_sclr_n = 1'b1;
        model_clear();
        chk("sclr_dp_err", 32'(dp_err), 32'(0));

        // Clear after a partial burst: no last flag; next burst restarts the count
        rd_beat(16'h6001, 2'd0);
        rd_beat(16'h6002, 2'd0);
        repeat (LAT + 1) idle();
        @(posedge mcb_clk); #1 mcb_sclr_n = 1'b0;
        @(posedge mcb_clk); #1 mcb_sclr_n = 1'b1;
        model_clear();
        chk("sclr_rdat", 32'(mcb_rdat), 32'(0));
        for (int i = 0; i < 4; i++)
            rd_beat(16'h7001 + 16'(i), 2'd0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
